// File: rtl/online_adder_mult_if.sv
// Operand/result bundle for online_adder_mult.
// When OL_BIN_OUT_EN is defined, the binary result z_bin is added to the bundle.
interface online_adder_mult_if #(
  parameter int STAGE = 8
);
  logic               en;
  logic               op;
  logic [2*STAGE-1:0] x;
  logic [2*STAGE-1:0] y;
  logic               cin;
  logic [4*STAGE-1:0] z;
  logic               z_valid;
`ifdef OL_BIN_OUT_EN
  logic [2*STAGE:0]   z_bin;
`endif

  modport master (
    output en, op, x, y, cin,
`ifdef OL_BIN_OUT_EN
    input  z_bin,
`endif
    input  z, z_valid
  );

  modport slave (
    input  en, op, x, y, cin,
`ifdef OL_BIN_OUT_EN
    output z_bin,
`endif
    output z, z_valid
  );
endinterface

// File: rtl/online_adder_mult.sv
// Registered radix-2 signed-digit online adder / multiplier (op selects), latency 2 edges.
// OL_BIN_OUT_EN adds a registered two's-complement copy of the result on z_bin.
module online_adder_mult #(
  parameter int STAGE = 8
) (
  input  logic               clk,
  input  logic               nrst,
  online_adder_mult_if.slave bus
);

  localparam int PW     = 2 * STAGE;
  localparam int LEVELS = $clog2(STAGE);
  // Tree vectors carry one spare digit per tree level so no transfer ever leaves the top.
  localparam int TW     = PW + LEVELS + 1;

  typedef logic signed [1:0] dval_t;
  typedef logic [2*TW-1:0]   sd_tree_t;
  typedef logic [2*PW-1:0]   sd_prod_t;

  typedef struct packed {
    logic               valid;
    logic               op;
    logic [2*STAGE-1:0] x;
    logic [2*STAGE-1:0] y;
    logic               cin;
  } opnd_t;

  // Digit {p,n} -> value p-n; 2'b11 reads as zero.
  function automatic dval_t dig_val(input logic [1:0] d);
    case (d)
      2'b10:   return 2'sb01;
      2'b01:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

  function automatic logic [1:0] dig_enc(input dval_t v);
    case (v)
      2'sb01:  return 2'b10;
      2'sb11:  return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] pp_digit(input logic [1:0] xd, input logic [1:0] yd);
    return dig_enc(dig_val(xd) * dig_val(yd));
  endfunction

  // Two-level carry-free SD addition. The transfer/interim split at each position looks
  // one digit down so interim+incoming transfer always stays in {-1,0,1}. cin enters as
  // the transfer into position 0, which is safe because position 0 assumes a
  // non-negative neighbour and so leaves room for a +1.
  function automatic sd_tree_t sd_add(input sd_tree_t a, input sd_tree_t b, input logic cin);
    dval_t      t [TW+1];
    dval_t      w [TW];
    dval_t      va;
    dval_t      vb;
    logic [2:0] s;
    logic       nonneg_prev;
    sd_tree_t   r;
    t[0]        = cin ? 2'sb01 : 2'sb00;
    nonneg_prev = 1'b1;
    for (int i = 0; i < TW; i++) begin
      va = dig_val(a[2*i +: 2]);
      vb = dig_val(b[2*i +: 2]);
      s  = {va[1], va} + {vb[1], vb};
      case (s)
        3'b010:  begin t[i+1] = 2'sb01; w[i] = 2'sb00; end
        3'b110:  begin t[i+1] = 2'sb11; w[i] = 2'sb00; end
        3'b001:  begin
          t[i+1] = nonneg_prev ? 2'sb01 : 2'sb00;
          w[i]   = nonneg_prev ? 2'sb11 : 2'sb01;
        end
        3'b111:  begin
          t[i+1] = nonneg_prev ? 2'sb00 : 2'sb11;
          w[i]   = nonneg_prev ? 2'sb11 : 2'sb01;
        end
        default: begin t[i+1] = 2'sb00; w[i] = 2'sb00; end
      endcase
      nonneg_prev = ~va[1] & ~vb[1];
    end
    for (int i = 0; i < TW; i++) r[2*i +: 2] = dig_enc(w[i] + t[i]);
    return r;
  endfunction

  // Partial products y_i * X << i, reduced pairwise by the SD adder.
  function automatic sd_tree_t sd_mult(input logic [2*STAGE-1:0] a, input logic [2*STAGE-1:0] b);
    sd_tree_t acc [2*STAGE];
    int       n;
    for (int i = 0; i < 2*STAGE; i++) acc[i] = '0;
    for (int i = 0; i < STAGE; i++) begin
      for (int j = 0; j < STAGE; j++) acc[i][2*(i+j) +: 2] = pp_digit(a[2*j +: 2], b[2*i +: 2]);
    end
    n = STAGE;
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int k = 0; k < STAGE; k++) begin
        if (2*k + 1 < n)  acc[k] = sd_add(acc[2*k], acc[2*k+1], 1'b0);
        else if (2*k < n) acc[k] = acc[2*k];
        else              acc[k] = '0;
      end
      n = (n + 1) / 2;
    end
    return acc[0];
  endfunction

  // Fold the tree's guard digits into PW digits. The guard+MSD segment is worth at most
  // +-2 units of the MSD; a +-2 is split into an MSD of +-1 and a string of +-1 digits
  // replacing the leading (necessarily opposite-signed) part of the lower digits.
  function automatic sd_prod_t sd_fit(input sd_tree_t v);
    int       top;
    dval_t    fix;
    logic     zero_above;
    sd_prod_t r;
    top = 0;
    for (int j = TW-1; j >= PW-1; j--) top = 2*top + int'(dig_val(v[2*j +: 2]));
    fix = (top > 1) ? 2'sb01 : (top < -1) ? 2'sb11 : 2'sb00;
    r   = v[2*PW-1:0];
    r[2*(PW-1) +: 2] = (top > 0) ? 2'b10 : (top < 0) ? 2'b01 : 2'b00;
    zero_above = 1'b1;
    for (int j = PW-2; j >= 0; j--) begin
      if (fix != 2'sb00 && zero_above) r[2*j +: 2] = dig_enc(fix);
      zero_above = zero_above & (dig_val(v[2*j +: 2]) == 2'sb00);
    end
    return r;
  endfunction

  opnd_t    in_d, in_q;
  sd_prod_t z_d, z_q;
  logic     z_valid_d, z_valid_q;
  sd_tree_t tree_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_d      = '0;
    z_d       = '0;
    z_valid_d = 1'b0;
    if (bus.en) in_d = '{valid: 1'b1, op: bus.op, x: bus.x, y: bus.y, cin: bus.cin};
    tree_sel = in_q.op ? sd_mult(in_q.x, in_q.y)
                       : sd_add(sd_tree_t'(in_q.x), sd_tree_t'(in_q.y), in_q.cin);
    if (bus.en && in_q.valid) begin
      z_d       = sd_fit(tree_sel);
      z_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: state updates use <= so every flop samples pre-edge values regardless of order.
    if (!nrst) begin
      in_q      <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
    end else begin
      in_q      <= in_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
    end
  end

  assign bus.z       = z_q;
  assign bus.z_valid = z_valid_q;

`ifdef OL_BIN_OUT_EN
  logic [PW-1:0] pos_bits;
  logic [PW-1:0] neg_bits;
  logic [PW:0]   z_bin_d, z_bin_q;

  // z_d never carries 2'b11, so the p and n rails are plain binary magnitudes.
  always_comb begin
    for (int i = 0; i < PW; i++) begin
      pos_bits[i] = z_d[2*i+1];
      neg_bits[i] = z_d[2*i];
    end
    z_bin_d = {1'b0, pos_bits} - {1'b0, neg_bits};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) z_bin_q <= '0;
    else       z_bin_q <= z_bin_d;
  end

  assign bus.z_bin = z_bin_q;
`endif

endmodule

// File: tb/tb_online_adder_mult.sv
// Directed and streamed checks for online_adder_mult (STAGE=8), decoding z by value.
module tb_online_adder_mult;
  localparam int STAGE = 8;

  logic clk = 1'b0;
  logic nrst;

  online_adder_mult_if #(.STAGE(STAGE)) bus ();
  online_adder_mult #(.STAGE(STAGE)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected contents of the input register (pend) and of z (out).
  logic   pend_v, out_v;
  logic   pend_op, out_op;
  longint pend_val, out_val;
  string  pend_tag, out_tag;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sd_value(input logic [4*STAGE-1:0] v, input int ndig);
    longint acc = 0;
    logic   p, n;
    for (int i = ndig - 1; i >= 0; i--) begin
      p   = v[2*i+1];
      n   = v[2*i];
      acc = 2*acc + longint'(p & ~n) - longint'(n & ~p);
    end
    return acc;
  endfunction

  function automatic longint count_11(input logic [4*STAGE-1:0] v);
    longint c = 0;
    for (int i = 0; i < 2*STAGE; i++) if (v[2*i +: 2] == 2'b11) c++;
    return c;
  endfunction

  function automatic longint model(input logic o, input logic [2*STAGE-1:0] a,
                                   input logic [2*STAGE-1:0] b, input logic c);
    longint va = sd_value((4*STAGE)'(a), STAGE);
    longint vb = sd_value((4*STAGE)'(b), STAGE);
    return o ? va * vb : va + vb + longint'(c);
  endfunction

  task automatic check_out();
    check({out_v ? out_tag : "empty", "_valid"}, longint'(bus.z_valid), longint'(out_v));
    if (out_v) begin
      check({out_tag, "_value"}, sd_value(bus.z, 2*STAGE), out_val);
      check({out_tag, "_legal"}, count_11(bus.z), 0);
      if (!out_op) check({out_tag, "_upper"}, longint'(bus.z[4*STAGE-1:2*STAGE+2]), 0);
`ifdef OL_BIN_OUT_EN
      check({out_tag, "_zbin"}, longint'($signed(bus.z_bin)), out_val);
`endif
    end else begin
      check("empty_z", longint'(bus.z), 0);
`ifdef OL_BIN_OUT_EN
      check("empty_zbin", longint'(bus.z_bin), 0);
`endif
    end
  endtask

  // Apply one cycle of inputs, let one rising edge pass, then check z at the negedge.
  task automatic step(input logic e, input logic o, input logic [2*STAGE-1:0] xx,
                      input logic [2*STAGE-1:0] yy, input logic c, input longint exp,
                      input string tag);
    bus.en = e; bus.op = o; bus.x = xx; bus.y = yy; bus.cin = c;
    @(negedge clk);
    if (e) begin
      out_v = pend_v; out_op = pend_op; out_val = pend_val; out_tag = pend_tag;
      pend_v = 1'b1; pend_op = o; pend_val = exp; pend_tag = tag;
    end else begin
      out_v  = 1'b0;
      pend_v = 1'b0;
    end
    check_out();
  endtask

  logic [2*STAGE-1:0] rx, ry;
  logic               rc;

  initial begin
    nrst = 1'b0;
    bus.en = 1'b0; bus.op = 1'b0; bus.x = '0; bus.y = '0; bus.cin = 1'b0;
    pend_v = 1'b0; out_v = 1'b0; pend_op = 1'b0; out_op = 1'b0;
    pend_val = 0; out_val = 0; pend_tag = "none"; out_tag = "none";

    #1;
    check("rst_z", longint'(bus.z), 0);
    check("rst_valid", longint'(bus.z_valid), 0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;

    step(1'b1, 1'b0, 16'h8000, 16'h4000, 1'b0,      0, "add_p1_m1");
    step(1'b1, 1'b0, 16'h8000, 16'h8000, 1'b0,    256, "add_two");
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1,      1, "add_cin");
    step(1'b1, 1'b0, 16'haaaa, 16'haaaa, 1'b1,    511, "add_all_pos");
    step(1'b1, 1'b0, 16'h5555, 16'h5555, 1'b1,   -509, "add_all_neg");
    step(1'b1, 1'b0, 16'hffff, 16'h8000, 1'b0,    128, "add_11_digits");
    step(1'b1, 1'b1, 16'h8000, 16'h0a2a, 1'b0,   7040, "mul_frac");
    step(1'b1, 1'b1, 16'h4000, 16'h4000, 1'b1,  16384, "mul_neg_neg");
    step(1'b1, 1'b1, 16'haaaa, 16'haaaa, 1'b0,  65025, "mul_max");
    step(1'b1, 1'b1, 16'h5555, 16'haaaa, 1'b0, -65025, "mul_min");
    step(1'b1, 1'b1, 16'h0a2a, 16'h02a0, 1'b0,   1540, "mul_frac2");
    step(1'b1, 1'b1, 16'h0a2a, 16'h4000, 1'b0,  -7040, "mul_sign");

    for (int i = 0; i < 24; i++) begin
      rx = (2*STAGE)'($urandom());
      ry = (2*STAGE)'($urandom());
      rc = 1'($urandom());
      step(1'b1, 1'(i % 2), rx, ry, rc, model(1'(i % 2), rx, ry, rc), $sformatf("rnd%0d", i));
      if (i == 11) step(1'b0, 1'b0, 16'h8000, 16'h8000, 1'b0, 0, "drop");
    end

    step(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0, 16384, "pre_rst");
    step(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1,   129, "pending_rst");
    #1 nrst = 1'b0;
    #1;
    check("rstpulse_z", longint'(bus.z), 0);
    check("rstpulse_valid", longint'(bus.z_valid), 0);
    #1 nrst = 1'b1;
    pend_v = 1'b0;
    out_v  = 1'b0;

    step(1'b1, 1'b1, 16'h8000, 16'h4000, 1'b0, -16384, "post_rst_mul");
    step(1'b1, 1'b0, 16'h4000, 16'h4000, 1'b0,   -256, "post_rst_add");
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0,      0, "flush");
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0,      0, "idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
